// File: rtl/dpd_pkg.sv
// Shared types and helpers for the DPD (densely packed decimal) declet unpacker.
package dpd_pkg;

    localparam int DECLET_W          = 10;
    localparam int DIGITS_PER_DECLET = 3;

    typedef logic [3:0]          bcd_digit_t;
    typedef logic [DECLET_W-1:0] declet_t;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    // 24 codes alias canonical 8/9 patterns: all-large-digit form with b9:8 set.
    function automatic logic is_noncanon(declet_t d);
        return (d[3:1] == 3'b111) && (d[6:5] == 2'b11) && (d[9:8] != 2'b00);
    endfunction

endpackage

// File: rtl/dpd_unpack_stream_if.sv
// Stream bundle for dpd_unpack_stream: word-in handshake and digit-out handshake.
interface dpd_unpack_stream_if #(
    parameter int DECLETS = 3
) ();
    import dpd_pkg::*;

    logic                        in_valid;
    logic                        in_ready;
    logic [DECLET_W*DECLETS-1:0] in_dpd;
    logic                        out_valid;
    logic                        out_ready;
    bcd_digit_t                  out_digit;
    logic                        out_first;
    logic                        out_last;
    logic                        out_noncanon;

    modport master (
        output in_valid, in_dpd, out_ready,
        input  in_ready, out_valid, out_digit, out_first, out_last, out_noncanon
    );

    modport slave (
        input  in_valid, in_dpd, out_ready,
        output in_ready, out_valid, out_digit, out_first, out_last, out_noncanon
    );

endinterface

// File: rtl/dpd_declet_unpack.sv
// Combinational decode of one 10-bit DPD declet into three BCD digits (d2 most significant).
module dpd_declet_unpack
    import dpd_pkg::*;
(
    input  declet_t    dpd,
    output bcd_digit_t d2,
    output bcd_digit_t d1,
    output bcd_digit_t d0,
    output logic       noncanon
);

    always_comb begin
        // NOTE: every output gets a value before any branch so no path leaves one unassigned (no latch).
        d2 = {1'b0, dpd[9:7]};
        d1 = {1'b0, dpd[6:4]};
        d0 = {1'b0, dpd[2:0]};
        if (dpd[3]) begin
            unique case (dpd[2:1])
                2'b00: begin
                    d0 = {3'b100, dpd[0]};
                end
                2'b01: begin
                    d1 = {3'b100, dpd[4]};
                    d0 = {1'b0, dpd[6:5], dpd[0]};
                end
                2'b10: begin
                    d2 = {3'b100, dpd[7]};
                    d0 = {1'b0, dpd[9:8], dpd[0]};
                end
                2'b11: begin
                    unique case (dpd[6:5])
                        2'b00: begin
                            d2 = {3'b100, dpd[7]};
                            d1 = {3'b100, dpd[4]};
                            d0 = {1'b0, dpd[9:8], dpd[0]};
                        end
                        2'b01: begin
                            d2 = {3'b100, dpd[7]};
                            d1 = {1'b0, dpd[9:8], dpd[4]};
                            d0 = {3'b100, dpd[0]};
                        end
                        2'b10: begin
                            d1 = {3'b100, dpd[4]};
                            d0 = {3'b100, dpd[0]};
                        end
                        2'b11: begin
                            // b9:8 ignored here, so non-canonical codes still decode to 8/9.
                            d2 = {3'b100, dpd[7]};
                            d1 = {3'b100, dpd[4]};
                            d0 = {3'b100, dpd[0]};
                        end
                    endcase
                end
            endcase
        end
    end

    assign noncanon = is_noncanon(dpd);

endmodule

// File: rtl/dpd_unpack_stream.sv
// Accepts a word of DECLETS packed declets and emits its BCD digits serially, MS first.
// Optional leading-zero suppression is enabled by defining DPD_LZ_SUPPRESS_EN.
module dpd_unpack_stream
    import dpd_pkg::*;
#(
    parameter int DECLETS = 3
) (
    input logic                clk,
    input logic                rst_n,
    dpd_unpack_stream_if.slave s
);

    localparam int NDIG  = DIGITS_PER_DECLET * DECLETS;
    localparam int IDX_W = $clog2(NDIG);

    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(NDIG - 1);

    bcd_digit_t         dec_d2 [DECLETS];
    bcd_digit_t         dec_d1 [DECLETS];
    bcd_digit_t         dec_d0 [DECLETS];
    logic [DECLETS-1:0] dec_nc;

    for (genvar k = 0; k < DECLETS; k++) begin : g_dec
        dpd_declet_unpack u_dec (
            .dpd      (s.in_dpd[DECLET_W*k +: DECLET_W]),
            .d2       (dec_d2[k]),
            .d1       (dec_d1[k]),
            .d0       (dec_d0[k]),
            .noncanon (dec_nc[k])
        );
    end

    // Digit index 0 is the most significant digit, i.e. d2 of the highest declet.
    bcd_digit_t new_dig [NDIG];
    always_comb begin
        new_dig = '{default: '0};
        for (int k = 0; k < DECLETS; k++) begin
            new_dig[DIGITS_PER_DECLET*(DECLETS-1-k)]     = dec_d2[k];
            new_dig[DIGITS_PER_DECLET*(DECLETS-1-k) + 1] = dec_d1[k];
            new_dig[DIGITS_PER_DECLET*(DECLETS-1-k) + 2] = dec_d0[k];
        end
    end

    idx_t start_new;
`ifdef DPD_LZ_SUPPRESS_EN
    always_comb begin
        start_new = LAST_IDX;
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (new_dig[i] != 4'd0) start_new = idx_t'(i);
        end
    end
`else
    assign start_new = '0;
`endif

    state_t             state_q, state_d;
    idx_t               index_q, index_d;
    idx_t               first_q;
    bcd_digit_t         digit_q [NDIG];
    logic [DECLETS-1:0] nc_q;

    logic drain, at_last, accept, fire, nc_sel;

    assign drain   = (state_q == DRAIN);
    assign at_last = drain && (index_q == LAST_IDX);

    assign s.in_ready     = !drain || (at_last && s.out_ready);
    assign s.out_valid    = drain;
    assign s.out_first    = drain && (index_q == first_q);
    assign s.out_last     = at_last;
    assign s.out_digit    = drain ? digit_q[index_q] : '0;
    assign s.out_noncanon = drain && nc_sel;

    assign accept = s.in_valid && s.in_ready;
    assign fire   = s.out_valid && s.out_ready;

    always_comb begin
        nc_sel = 1'b0;
        for (int k = 0; k < DECLETS; k++) begin
            if (int'(index_q) / DIGITS_PER_DECLET == DECLETS - 1 - k) nc_sel = nc_q[k];
        end
    end

    // A word accepted on the final-digit handshake reloads and keeps draining with no bubble.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = DRAIN;
                    index_d = start_new;
                end
            end
            DRAIN: begin
                if (accept) begin
                    index_d = start_new;
                end else if (fire) begin
                    if (at_last) begin
                        state_d = IDLE;
                        index_d = '0;
                    end else begin
                        index_d = index_q + idx_t'(1);
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            index_q <= '0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            if (accept) first_q <= start_new;
        end
    end

    // NOTE: the digit store is deliberately not reset; outputs are gated by state, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (accept) begin
            digit_q <= new_dig;
            nc_q    <= dec_nc;
        end
    end

endmodule

// File: tb/tb_dpd_unpack_stream.sv
// Scoreboard bench for dpd_unpack_stream: directed words, backpressure, back-to-back, reset mid-drain.
module tb_dpd_unpack_stream;
    import dpd_pkg::*;

    localparam int DECLETS = 3;
    localparam int NDIG    = 9;

    typedef struct packed {
        logic [3:0] digit;
        logic       first;
        logic       last;
        logic       nc;
    } exp_t;

    typedef logic [3:0] dig_arr_t [NDIG];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    int   hs_cycles[$];
    bit   bp_mode = 1'b0;
    int   bp_i    = 0;
    bit   bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    dpd_unpack_stream_if #(.DECLETS(DECLETS)) bus ();

    dpd_unpack_stream #(.DECLETS(DECLETS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer ready: constant 1, or the 1,0,0,1 pattern while backpressure is enabled.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                bus.out_ready = bp_pat[bp_i % 4];
                bp_i++;
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks outputs stay frozen while stalled.
    exp_t held;
    bit   held_v = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) check("stall_valid", bus.out_valid, 1);
            if (bus.out_valid) begin
                if (held_v) begin
                    check("stall_digit", bus.out_digit, held.digit);
                    check("stall_first", bus.out_first, held.first);
                    check("stall_last", bus.out_last, held.last);
                    check("stall_nc", bus.out_noncanon, held.nc);
                end
                held.digit = bus.out_digit;
                held.first = bus.out_first;
                held.last  = bus.out_last;
                held.nc    = bus.out_noncanon;
                held_v     = !bus.out_ready;
                if (bus.out_ready) begin
                    hs_cycles.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        check("spurious_digit_queue_depth", exp_q.size(), 1);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("digit", bus.out_digit, e.digit);
                        check("first", bus.out_first, e.first);
                        check("last", bus.out_last, e.last);
                        check("noncanon", bus.out_noncanon, e.nc);
                        check("in_ready_hs", bus.in_ready, e.last);
                    end
                end else begin
                    check("in_ready_stall", bus.in_ready, 0);
                end
            end else begin
                held_v = 1'b0;
                check("in_ready_idle", bus.in_ready, 1);
            end
        end
    end

    task automatic push_word(input dig_arr_t dg, input logic [0:NDIG-1] ncm);
        int   start;
        exp_t e;
        start = 0;
`ifdef DPD_LZ_SUPPRESS_EN
        start = NDIG - 1;
        for (int i = NDIG - 1; i >= 0; i--) if (dg[i] != 4'd0) start = i;
`endif
        for (int i = start; i < NDIG; i++) begin
            e.digit = dg[i];
            e.first = (i == start);
            e.last  = (i == NDIG - 1);
            e.nc    = ncm[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic send_word(input logic [29:0] w, input dig_arr_t dg, input logic [0:NDIG-1] ncm);
        bit ok;
        push_word(dg, ncm);
        bus.in_dpd   = w;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", ok, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0 && !bus.out_valid) break;
        end
        check("drain_timeout_pending", exp_q.size(), 0);
    endtask

    localparam logic [29:0] W1 = {10'h0A3, 10'h0FF, 10'h000};
    localparam logic [29:0] W2 = {10'h3FF, 10'h0A3, 10'h0A3};
    localparam logic [29:0] W3 = {10'h0A3, 10'h0A3, 10'h0A3};
    localparam logic [29:0] W4 = {10'h000, 10'h000, 10'h0A3};
    localparam logic [29:0] W5 = 30'h0;
    localparam logic [29:0] W6 = {10'h0A8, 10'h1DB, 10'h34D};
    localparam logic [29:0] W7 = {10'h38E, 10'h23F, 10'h3CF};

    initial begin
        int b;
        bus.in_valid = 1'b0;
        bus.in_dpd   = '0;

        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_first", bus.out_first, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_noncanon", bus.out_noncanon, 0);
        check("rst_out_digit", bus.out_digit, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        send_word(W1, '{4'd1, 4'd2, 4'd3, 4'd9, 4'd9, 4'd9, 4'd0, 4'd0, 4'd0}, 9'b000000000);
        wait_idle();
        send_word(W2, '{4'd9, 4'd9, 4'd9, 4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3}, 9'b111000000);
        wait_idle();
        send_word(W6, '{4'd1, 4'd2, 4'd8, 4'd3, 4'd9, 4'd5, 4'd8, 4'd4, 4'd7}, 9'b000000000);
        send_word(W7, '{4'd9, 4'd8, 4'd6, 4'd8, 4'd5, 4'd9, 4'd7, 4'd8, 4'd9}, 9'b000000000);
        wait_idle();

        bp_mode = 1'b1;
        send_word(W1, '{4'd1, 4'd2, 4'd3, 4'd9, 4'd9, 4'd9, 4'd0, 4'd0, 4'd0}, 9'b000000000);
        wait_idle();
        bp_mode = 1'b0;
        @(posedge clk);
        #1;

        b = hs_cycles.size();
        send_word(W3, '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3}, 9'b000000000);
        send_word(W3, '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3}, 9'b000000000);
        wait_idle();
        check("b2b_digit_count", hs_cycles.size() - b, 18);
        if (hs_cycles.size() >= b + 18) check("b2b_span_cycles", hs_cycles[b+17] - hs_cycles[b], 17);

        b = hs_cycles.size();
        send_word(W1, '{4'd1, 4'd2, 4'd3, 4'd9, 4'd9, 4'd9, 4'd0, 4'd0, 4'd0}, 9'b000000000);
        for (int n = 0; n < 50; n++) begin
            if (hs_cycles.size() >= b + 4) break;
            @(posedge clk);
            #1;
        end
        check("mid_rst_digits_before", hs_cycles.size() - b, 4);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_digit", bus.out_digit, 0);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_idle_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        send_word(W1, '{4'd1, 4'd2, 4'd3, 4'd9, 4'd9, 4'd9, 4'd0, 4'd0, 4'd0}, 9'b000000000);
        wait_idle();

        send_word(W4, '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3}, 9'b000000000);
        wait_idle();
        send_word(W5, '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 9'b000000000);
        wait_idle();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpd_unpack_stream.md
Name: dpd_unpack_stream

Overview:
- Downstream consumer of DPD-encoded data: accepts one word of DECLETS packed 10-bit declets and emits the 3*DECLETS BCD digits serially, most significant first, over a valid/ready stream.
- Sits between packed-decimal storage or a bus and digit-serial consumers such as display drivers, ASCII formatters or serial BCD ALUs.
- Flags non-canonical declets.

Parameters:
- DECLETS, 3, number of declets per input word (>=1); the block emits NDIG = 3*DECLETS digits per word.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, input word valid.
- in_ready, output, 1, block can accept a word this cycle.
- in_dpd, input, 10*DECLETS, packed word; declet k is in_dpd[10k+9:10k]; the highest declet is most significant.
- out_valid, output, 1, out_digit is valid.
- out_ready, input, 1, consumer accepts a digit.
- out_digit, output, 4, BCD digit, 0..9.
- out_first, output, 1, first digit emitted for the word.
- out_last, output, 1, final digit emitted for the word.
- out_noncanon, output, 1, the source declet of this digit was non-canonical.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, index=0.
  - out_valid=0, out_first=0, out_last=0, out_noncanon=0, out_digit=0.
  - in_ready=1 once reset is released.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: decode every declet combinationally, register NDIG digits plus DECLETS noncanon bits, index=0, go to DRAIN.
- State DRAIN:
  - out_valid=1, out_digit=digit[index], out_first=(index==0), out_last=(index==NDIG-1).
  - out_noncanon = noncanon bit of declet (NDIG-1-index)/3.
  - On out_valid&out_ready: index++; if out_last, go to IDLE.
- Back-to-back words:
  - in_ready = IDLE | (DRAIN & out_last & out_ready). This is combinational from out_ready; no combinational path from in_valid to out_*.
  - If a new word is accepted on the last-digit handshake, reload, index=0 and stay in DRAIN.
  - Sustained throughput is one digit per cycle.
- Latency: accept edge -> out_valid high on the next cycle. Holding out_ready=0 freezes every output stably.
- Declet decode, on bits b9..b0:
  - b3=0: d2={0,b9:7}, d1={0,b6:4}, d0={0,b2:0}.
  - b3:1=100: d2={0,b9:7}, d1={0,b6:4}, d0={100,b0}.
  - b3:1=101: d2={0,b9:7}, d1={100,b4}, d0={0,b6:5,b0}.
  - b3:1=110: d2={100,b7}, d1={0,b6:4}, d0={0,b9:8,b0}.
  - b3:1=111, then by b6:5:
    - 00: d2={100,b7}, d1={100,b4}, d0={0,b9:8,b0}.
    - 01: d2={100,b7}, d1={0,b9:8,b4}, d0={100,b0}.
    - 10: d2={0,b9:7}, d1={100,b4}, d0={100,b0}.
    - 11: all three digits are 8/9 from b7, b4, b0; b9:8 are ignored.
  - Digit order within a declet is d2, d1, d0.
- Non-canonical: b3:1=111 & b6:5=11 & b9:8!=00 (24 codes). Decoded as above with noncanon=1 on all three digits. The block never outputs a digit above 9.
- in_valid is ignored while in_ready=0; the word must be held by the producer.
- Reset mid-DRAIN: remaining digits are discarded and the next handshake starts clean.

Optional Feature:
- Macro: DPD_LZ_SUPPRESS_EN.
- Defined:
  - At load, index starts at the first nonzero digit.
  - An all-zero word emits a single digit 0 with out_first=out_last=1.
  - out_first marks the first emitted digit.
  - Throughput per word is the number of significant digits.
- Undefined: all NDIG digits are always emitted, including leading zeros.

Decomposition:
- Package dpd_pkg:
  - typedef bcd_digit_t (4 bits), typedef declet_t (10 bits).
  - constants DECLET_W=10, DIGITS_PER_DECLET=3.
  - function is_noncanon(declet_t).
- Sub-module dpd_declet_unpack: combinational; declet_t in -> three bcd_digit_t plus noncanon; instantiated DECLETS times by generate.
- Top module: holds the FSM, the digit register array and the index counter ($clog2(NDIG) bits).

Test Plan:
1. DECLETS=3, in_dpd={0x0A3,0x0FF,0x000}, out_ready=1 -> digits 1,2,3,9,9,9,0,0,0 on consecutive cycles; first on digit 1, last on the final 0, noncanon=0 throughout.
2. in_dpd={0x3FF,0x0A3,0x0A3} -> digits 9,9,9,1,2,3,1,2,3; noncanon=1 only on the first three digits.
3. Backpressure: out_ready toggles 1,0,0,1,... during test 1 -> out_digit, out_first, out_last held while stalled; sequence unchanged; no digit lost or duplicated.
4. Back-to-back: second word 0x0A3-repeated presented with in_valid held high -> accepted on the last-digit handshake (in_ready=1 that cycle); 18 digits in 18 cycles with no bubble.
5. Reset asserted asynchronously mid-DRAIN at index 4 -> out_valid=0 immediately; after release in_ready=1; the next word drains from index 0.
6. With DPD_LZ_SUPPRESS_EN:
   - {0x000,0x000,0x0A3} -> 1,2,3 with first on 1.
   - An all-zero word -> a single 0 with first=last=1.
